comp_decomp_scheduler: RTL and testbench

COMP_DECOMP_SCHEDULER -- requirements
Module: comp_decomp_scheduler

---
 rtl/comp_decomp_pkg.sv | 26 ++
 rtl/comp_decomp_rr_arb.sv | 20 ++
 rtl/comp_decomp_scheduler.sv | 174 +++++++++++++++++
 tb/tb_comp_decomp_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/comp_decomp_pkg.sv
// comp_decomp_pkg: shared encodings and widths for the compress/decompress scheduler.
package comp_decomp_pkg;
    localparam int DATA_W = 80;
    localparam int COMP_W = 8;

    typedef enum logic [1:0] {
        CMD_NOP    = 2'b00,
        CMD_COMP   = 2'b01,
        CMD_DECOMP = 2'b10,
        CMD_RSVD   = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        RSP_NONE = 2'b00,
        RSP_OK   = 2'b01,
        RSP_REJ  = 2'b10,
        RSP_TMO  = 2'b11
    } rsp_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;
endpackage

// File: rtl/comp_decomp_rr_arb.sv
// comp_decomp_rr_arb: two-requester round-robin arbiter; ptr_q names the requester favoured on a tie.
module comp_decomp_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic ptr_q, ptr_d;

    always_comb begin
        gnt[0] = en & req[0] & (~req[1] | ~ptr_q);
        gnt[1] = en & req[1] & (~req[0] | ptr_q);
        ptr_d  = (|gnt) ? gnt[0] : ptr_q;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
endmodule

// File: rtl/comp_decomp_scheduler.sv
// comp_decomp_scheduler: arbitrates two requesters onto one compress/decompress engine with timeout.
// Optional statistics counters enabled by defining COMP_DECOMP_SCHED_STATS_EN.
module comp_decomp_scheduler
    import comp_decomp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req0_command,
    input  logic [1:0]        req1_command,
    input  logic [DATA_W-1:0] req0_data_in,
    input  logic [DATA_W-1:0] req1_data_in,
    input  logic [COMP_W-1:0] req0_compressed_in,
    input  logic [COMP_W-1:0] req1_compressed_in,
    output logic [1:0]        rsp_valid,
    output logic [1:0]        rsp_code,
    output logic [COMP_W-1:0] rsp_compressed_out,
    output logic [DATA_W-1:0] rsp_decompressed_out,
    output logic [1:0]        eng_command,
    output logic [DATA_W-1:0] eng_data_in,
    output logic [COMP_W-1:0] eng_compressed_in,
    input  logic [COMP_W-1:0] eng_compressed_out,
    input  logic [DATA_W-1:0] eng_decompressed_out,
    input  logic [1:0]        eng_response,
    output logic [15:0]       stat_done_cnt,
    output logic [15:0]       stat_timeout_cnt
);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    cmd_e                cmd_q, cmd_d;
    rsp_e                res_code_q, res_code_d, rsp_code_q, rsp_code_d;
    logic                owner_q, owner_d, rsp_valid_q, rsp_valid_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d, res_dec_q, res_dec_d, rsp_dec_q, rsp_dec_d;
    logic [COMP_W-1:0]   comp_q, comp_d, res_comp_q, res_comp_d, rsp_comp_q, rsp_comp_d;
    logic [1:0]          gnt;
    cmd_e                sel_cmd;

    comp_decomp_rr_arb u_arb (
        .clk  (clk),
        .reset(reset),
        .en   (state_q == S_IDLE),
        .req  (req_valid),
        .gnt  (gnt)
    );

    assign sel_cmd = cmd_e'(gnt[1] ? req1_command : req0_command);

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        owner_d     = owner_q;
        data_d      = data_q;
        comp_d      = comp_q;
        cnt_d       = cnt_q;
        res_code_d  = res_code_q;
        res_comp_d  = res_comp_q;
        res_dec_d   = res_dec_q;
        rsp_valid_d = 1'b0;
        rsp_code_d  = RSP_NONE;
        rsp_comp_d  = rsp_comp_q;
        rsp_dec_d   = rsp_dec_q;
        case (state_q)
            S_IDLE: if (|gnt) begin
                owner_d = gnt[1];
                cmd_d   = sel_cmd;
                data_d  = gnt[1] ? req1_data_in : req0_data_in;
                comp_d  = gnt[1] ? req1_compressed_in : req0_compressed_in;
                // nop and reserved complete locally without touching the engine
                if (sel_cmd == CMD_COMP || sel_cmd == CMD_DECOMP) begin
                    state_d = S_ISSUE;
                end else begin
                    res_code_d = (sel_cmd == CMD_NOP) ? RSP_OK : RSP_REJ;
                    res_comp_d = '0;
                    res_dec_d  = '0;
                    state_d    = S_DONE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: if (eng_response != 2'b00) begin
                res_code_d = (eng_response == 2'b01) ? RSP_OK : RSP_REJ;
                res_comp_d = eng_compressed_out;
                res_dec_d  = eng_decompressed_out;
                state_d    = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
                res_code_d = RSP_TMO;
                res_comp_d = '0;
                res_dec_d  = '0;
                state_d    = S_DONE;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            S_DONE: begin
                rsp_valid_d = 1'b1;
                rsp_code_d  = res_code_q;
                rsp_comp_d  = res_comp_q;
                rsp_dec_d   = res_dec_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q     <= S_IDLE;
            cmd_q       <= CMD_NOP;
            owner_q     <= 1'b0;
            data_q      <= '0;
            comp_q      <= '0;
            cnt_q       <= '0;
            res_code_q  <= RSP_NONE;
            res_comp_q  <= '0;
            res_dec_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= RSP_NONE;
            rsp_comp_q  <= '0;
            rsp_dec_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            owner_q     <= owner_d;
            data_q      <= data_d;
            comp_q      <= comp_d;
            cnt_q       <= cnt_d;
            res_code_q  <= res_code_d;
            res_comp_q  <= res_comp_d;
            res_dec_q   <= res_dec_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_code_q  <= rsp_code_d;
            rsp_comp_q  <= rsp_comp_d;
            rsp_dec_q   <= rsp_dec_d;
        end

    assign req_ready            = gnt;
    assign rsp_valid            = rsp_valid_q ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_code             = rsp_code_q;
    assign rsp_compressed_out   = rsp_comp_q;
    assign rsp_decompressed_out = rsp_dec_q;
    assign eng_command          = (state_q == S_ISSUE) ? cmd_q : CMD_NOP;
    assign eng_data_in          = data_q;
    assign eng_compressed_in    = comp_q;

`ifdef COMP_DECOMP_SCHED_STATS_EN
    logic [15:0] done_q, done_d, tmo_q, tmo_d;

    always_comb begin
        done_d = (state_q == S_DONE && done_q != 16'hFFFF) ? done_q + 16'd1 : done_q;
        tmo_d  = (state_q == S_DONE && res_code_q == RSP_TMO && tmo_q != 16'hFFFF) ? tmo_q + 16'd1 : tmo_q;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            done_q <= '0;
            tmo_q  <= '0;
        end else begin
            done_q <= done_d;
            tmo_q  <= tmo_d;
        end

    assign stat_done_cnt    = done_q;
    assign stat_timeout_cnt = tmo_q;
`else
    assign stat_done_cnt    = '0;
    assign stat_timeout_cnt = '0;
`endif
endmodule

// File: tb/tb_comp_decomp_scheduler.sv
// tb_comp_decomp_scheduler: directed table-driven bench with a cycle-counting engine model.
module tb_comp_decomp_scheduler;
    import comp_decomp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready, req0_command, req1_command;
    logic [79:0] req0_data_in, req1_data_in;
    logic [7:0]  req0_compressed_in, req1_compressed_in;
    logic [1:0]  rsp_valid, rsp_code, eng_command, eng_response;
    logic [7:0]  rsp_compressed_out, eng_compressed_in, eng_compressed_out;
    logic [79:0] rsp_decompressed_out, eng_data_in, eng_decompressed_out;
    logic [15:0] stat_done_cnt, stat_timeout_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    comp_decomp_scheduler dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req0_command        (req0_command),
        .req1_command        (req1_command),
        .req0_data_in        (req0_data_in),
        .req1_data_in        (req1_data_in),
        .req0_compressed_in  (req0_compressed_in),
        .req1_compressed_in  (req1_compressed_in),
        .rsp_valid           (rsp_valid),
        .rsp_code            (rsp_code),
        .rsp_compressed_out  (rsp_compressed_out),
        .rsp_decompressed_out(rsp_decompressed_out),
        .eng_command         (eng_command),
        .eng_data_in         (eng_data_in),
        .eng_compressed_in   (eng_compressed_in),
        .eng_compressed_out  (eng_compressed_out),
        .eng_decompressed_out(eng_decompressed_out),
        .eng_response        (eng_response),
        .stat_done_cnt       (stat_done_cnt),
        .stat_timeout_cnt    (stat_timeout_cnt)
    );

    typedef struct {
        logic [1:0]  rv;
        logic [1:0]  c0;
        logic [1:0]  c1;
        int          dly;   // WAIT cycle carrying the engine response, 0 = never
        logic [1:0]  resp;
        logic [7:0]  ec;
        logic [79:0] ed;
        logic [1:0]  gnt;
        logic [1:0]  ecmd;
        logic [1:0]  code;
        int          lat;
        logic        chkd;
        logic [7:0]  xc;
        logic [79:0] xd;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run(input int idx, input vec_t v);
        logic seen;
        logic bad;
        int   lat;
        req_valid            = v.rv;
        req0_command         = v.c0;
        req1_command         = v.c1;
        eng_compressed_out   = v.ec;
        eng_decompressed_out = v.ed;
        eng_response         = 2'b00;
        #1;
        chk($sformatf("v%0d_req_ready", idx), req_ready, v.gnt);
        @(negedge clk);
        req_valid = 2'b00;
        seen = 1'b0;
        bad  = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            eng_response = (v.dly != 0 && k == 1 + v.dly) ? v.resp : 2'b00;
            #1;
            if (k == 1) begin
                chk($sformatf("v%0d_eng_cmd_issue", idx), eng_command, v.ecmd);
                if (v.ecmd != 2'b00) begin
                    chk($sformatf("v%0d_eng_data", idx), eng_data_in, v.gnt[1] ? req1_data_in : req0_data_in);
                    chk($sformatf("v%0d_eng_comp", idx), eng_compressed_in, v.gnt[1] ? req1_compressed_in : req0_compressed_in);
                end
            end else if (eng_command != 2'b00) begin
                bad = 1'b1;
            end
            if (rsp_valid != 2'b00) begin
                seen = 1'b1;
                lat  = k;
                chk($sformatf("v%0d_rsp_valid", idx), rsp_valid, v.gnt);
                chk($sformatf("v%0d_rsp_code", idx), rsp_code, v.code);
                if (v.chkd) begin
                    chk($sformatf("v%0d_rsp_comp", idx), rsp_compressed_out, v.xc);
                    chk($sformatf("v%0d_rsp_dec", idx), rsp_decompressed_out, v.xd);
                end
            end else begin
                @(negedge clk);
            end
        end
        chk($sformatf("v%0d_latency", idx), lat, v.lat);
        chk($sformatf("v%0d_eng_cmd_quiet", idx), bad, 1'b0);
        eng_response = 2'b00;
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_pulse_end", idx), {rsp_valid, rsp_code}, 4'b0000);
        if (v.chkd) chk($sformatf("v%0d_hold", idx), rsp_compressed_out, v.xc);
    endtask

    initial begin
        int   ng;
        logic bad;
        reset                = 1'b1;
        req_valid            = '0;
        req0_command         = '0;
        req1_command         = '0;
        req0_data_in         = {10{8'h55}};
        req1_data_in         = {10{8'hC3}};
        req0_compressed_in   = 8'h3C;
        req1_compressed_in   = 8'h81;
        eng_compressed_out   = '0;
        eng_decompressed_out = '0;
        eng_response         = '0;

        //           rv     c0     c1     dly resp   ec     ed            gnt    ecmd   code   lat chkd xc     xd
        tbl[0] = '{2'b01, 2'b01, 2'b00, 4,  2'b01, 8'hA5, 80'h1234,     2'b01, 2'b01, 2'b01, 7,  1, 8'hA5, 80'h1234};
        tbl[1] = '{2'b10, 2'b00, 2'b10, 1,  2'b01, 8'h5A, 80'hDEADBEEF, 2'b10, 2'b10, 2'b01, 4,  1, 8'h5A, 80'hDEADBEEF};
        tbl[2] = '{2'b11, 2'b01, 2'b10, 2,  2'b11, 8'h77, 80'h77,       2'b01, 2'b01, 2'b10, 5,  1, 8'h77, 80'h77};
        tbl[3] = '{2'b01, 2'b00, 2'b00, 0,  2'b00, 8'h00, 80'h0,        2'b01, 2'b00, 2'b01, 2,  0, 8'h00, 80'h0};
        tbl[4] = '{2'b11, 2'b10, 2'b11, 0,  2'b00, 8'h00, 80'h0,        2'b10, 2'b00, 2'b10, 2,  0, 8'h00, 80'h0};
        tbl[5] = '{2'b01, 2'b01, 2'b00, 0,  2'b00, 8'hEE, 80'hEE,       2'b01, 2'b01, 2'b11, 19, 1, 8'h00, 80'h0};
        tbl[6] = '{2'b01, 2'b10, 2'b00, 16, 2'b10, 8'h42, 80'h42,       2'b01, 2'b10, 2'b10, 19, 1, 8'h42, 80'h42};
        tbl[7] = '{2'b10, 2'b00, 2'b01, 15, 2'b01, 8'h99, 80'h99,       2'b10, 2'b01, 2'b01, 18, 1, 8'h99, 80'h99};

        #12;
        chk("reset_outputs", {req_ready, rsp_valid, rsp_code, eng_command}, 8'h00);
        chk("reset_rsp_data", {rsp_compressed_out, rsp_decompressed_out}, 88'h0);
        chk("reset_eng_data", {eng_compressed_in, eng_data_in}, 88'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run(i, tbl[i]);

`ifdef COMP_DECOMP_SCHED_STATS_EN
        chk("stat_done", stat_done_cnt, 16'd8);
        chk("stat_timeout", stat_timeout_cnt, 16'd1);
`else
        chk("stat_done", stat_done_cnt, 16'd0);
        chk("stat_timeout", stat_timeout_cnt, 16'd0);
`endif

        // both requesters held: grants must alternate
        req0_command = 2'b00;
        req1_command = 2'b00;
        req_valid    = 2'b11;
        ng = 0;
        for (int i = 0; i < 40 && ng < 4; i++) begin
            #1;
            if (req_ready != 2'b00) begin
                chk($sformatf("rr_grant%0d", ng), req_ready, (ng % 2 == 0) ? 2'b01 : 2'b10);
                ng++;
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        chk("rr_count", ng, 4);
        repeat (3) @(negedge clk);

        // reset while waiting on a silent engine
        req1_command = 2'b01;
        req_valid    = 2'b10;
        #1;
        chk("rst_seq_grant", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (4) @(negedge clk);
        #1;
        chk("rst_seq_eng_data_before", eng_data_in, req1_data_in);
        reset = 1'b1;
        #1;
        chk("rst_mid_outputs", {req_ready, rsp_valid, rsp_code, eng_command}, 8'h00);
        chk("rst_mid_eng_data", {eng_compressed_in, eng_data_in}, 88'h0);
        chk("rst_mid_rsp_data", {rsp_compressed_out, rsp_decompressed_out}, 88'h0);
        chk("rst_mid_stats", {stat_done_cnt, stat_timeout_cnt}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bad = 1'b0;
        repeat (25) begin
            @(negedge clk);
            #1;
            if (rsp_valid != 2'b00) bad = 1'b1;
        end
        chk("rst_no_rsp", bad, 1'b0);
        req0_command = 2'b00;
        req1_command = 2'b00;
        req_valid    = 2'b11;
        #1;
        chk("rst_ptr_grant0", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
